mux8_rr_arbiter: RTL

- Shares one 8-input, 8-bit mux datapath among 8 requesters using round-robin arbitration with packet locking.
- Each requester presents a valid/last/data stream. The block grants one requester at a time and drives the mux select S.
- It forwards the granted beats through a single registered output stage with a valid/ready handshake.
- Sits between requester ports and the shared downstream consumer; the S output feeds the 8x8 mux select.

---
 rtl/mux8_rr_arbiter_pkg.sv | 18 +
 rtl/mux8_rr_arbiter_pick.sv | 28 ++
 rtl/mux8_rr_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and index helper for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

  localparam int N                 = 8;
  localparam int SEL_W             = 3;
  localparam int DEFAULT_MAX_BEATS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Wraps for free because N is exactly 2**SEL_W.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    return idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_pick.sv
// Rotating priority encoder: first set request bit scanning ptr, ptr+1, ... modulo N.
module rr_priority_pick
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // NOTE: every output gets a default before the loop, so no path can infer a latch.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = ptr;
    // Walk from the farthest offset back towards ptr so the nearest hit overwrites last.
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter with packet locking driving an 8:1 mux select and a registered output stage.
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = DEFAULT_MAX_BEATS
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0]         req_last,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         req_ready,
  output logic [SEL_W-1:0]     S,
  output logic [WIDTH-1:0]     O,
  output logic                 O_valid,
  output logic                 O_last,
  input  logic                 O_ready,
  output logic                 busy
);

  localparam int              CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] sel_data;
  logic             slot_free;
  logic             accept;
  logic             release_now;

  rr_priority_pick u_pick (
    .req (req_valid),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign sel_data    = req_data[int'(S)*WIDTH +: WIDTH];
  // The output register can take a new beat if it is empty or being drained this cycle.
  assign slot_free   = !O_valid || O_ready;
  assign accept      = (state == LOCK) && req_valid[S] && slot_free;
  assign release_now = accept && (req_last[S] || (beat_cnt == LAST_CNT));
  assign busy        = (state == LOCK);

  always_comb begin
    req_ready = '0;
    if (state == LOCK) req_ready[S] = slot_free;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state    <= IDLE;
      ptr      <= '0;
      S        <= '0;
      beat_cnt <= '0;
      O        <= '0;
      O_valid  <= 1'b0;
      O_last   <= 1'b0;
    end else begin
      if (accept) begin
        O       <= sel_data;
        O_last  <= req_last[S];
        O_valid <= 1'b1;
      end else if (O_ready) begin
        O_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            S        <= pick_idx;
            beat_cnt <= '0;
            state    <= LOCK;
          end
        end
        LOCK: begin
          if (accept) beat_cnt <= beat_cnt + CNT_W'(1);
          // A forced release leaves O_last as the requester drove it.
          if (release_now) begin
            ptr   <= next_idx(S);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
